// File: rtl/fd_de_pipe.sv
// fd_de_pipe: fetch PC, IF/ID and ID/EX pipeline registers of the 5-stage MIPS
// pipeline, steered by StallF, StallD and FlushE from the hazard unit.
// Branches use delay slots, so a taken PCSrcD only redirects the PC and never
// squashes IF/ID.
// Optional feature macro: PIPE_PERF_CNT_EN -- when defined, saturating
// stall-cycle (StallCnt) and displaced-instruction (BubbleCnt) counters are
// built; when undefined both outputs are tied to zero and no counter flops exist.
module fd_de_pipe #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushE,
  input  logic        PCSrcD,
  input  logic [31:0] NPCD,
  input  logic [31:0] InstrF,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] ExtD,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PC8D,
  output logic        ValidD,
  output logic [31:0] InstrE,
  output logic [31:0] PC8E,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ExtE,
  output logic        ValidE,
  output logic [31:0] StallCnt,
  output logic [31:0] BubbleCnt
);

  logic stallFOn;
  logic stallDOn;
  logic flushEOn;
  logic pcSrcDOn;

  // Hazard controls that are X/Z early after reset count as deasserted so the pipe keeps moving
  always_comb begin
    stallFOn = (StallF === 1'b1);
    stallDOn = (StallD === 1'b1);
    flushEOn = (FlushE === 1'b1);
    pcSrcDOn = (PCSrcD === 1'b1);
  end

  // Fetch PC: a stall beats a redirect; the branch stays in D and re-requests next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      PCF <= RESET_PC;
    end else if (stallFOn) begin
      PCF <= PCF;
    end else if (pcSrcDOn) begin
      PCF <= NPCD;
    end else begin
      PCF <= PCF + 32'd4;
    end
  end

  // IF/ID register: holds on StallD, otherwise latches the fetched word and its link address
  always_ff @(posedge clk) begin
    if (reset) begin
      InstrD <= NOP_INSTR;
      PC8D   <= 32'd0;
      ValidD <= 1'b0;
    end else if (!stallDOn) begin
      InstrD <= InstrF;
      PC8D   <= PCF + 32'd8;
      ValidD <= 1'b1;
    end
  end

  // ID/EX register: FlushE inserts a bubble, otherwise the decoded instruction moves to E
  always_ff @(posedge clk) begin
    if (reset || flushEOn) begin
      InstrE <= NOP_INSTR;
      PC8E   <= 32'd0;
      RD1E   <= 32'd0;
      RD2E   <= 32'd0;
      ExtE   <= 32'd0;
      ValidE <= 1'b0;
    end else begin
      InstrE <= InstrD;
      PC8E   <= PC8D;
      RD1E   <= RD1D;
      RD2E   <= RD2D;
      ExtE   <= ExtD;
      ValidE <= ValidD;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating counters of stalled cycles and of real instructions displaced by a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt  <= 32'd0;
      BubbleCnt <= 32'd0;
    end else begin
      if (stallDOn && (StallCnt != 32'hFFFF_FFFF)) begin
        StallCnt <= StallCnt + 32'd1;
      end
      if (flushEOn && ValidD && (BubbleCnt != 32'hFFFF_FFFF)) begin
        BubbleCnt <= BubbleCnt + 32'd1;
      end
    end
  end
`else
  assign StallCnt  = 32'd0;
  assign BubbleCnt = 32'd0;
`endif

endmodule

// File: tb/tb_fd_de_pipe.sv
// tb_fd_de_pipe: scoreboard bench for fd_de_pipe. The driver applies one set of
// inputs per cycle, advances a stage-level reference model and queues the
// expected register view; an independent monitor pops and compares after each
// rising edge.
module tb_fd_de_pipe;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        StallF, StallD, FlushE, PCSrcD;
  logic [31:0] NPCD, InstrF, RD1D, RD2D, ExtD;
  logic [31:0] PCF, InstrD, PC8D, InstrE, PC8E, RD1E, RD2E, ExtE;
  logic        ValidD, ValidE;
  logic [31:0] StallCnt, BubbleCnt;

  typedef struct packed {
    logic [31:0] pcF;
    logic [31:0] instrD;
    logic [31:0] pc8D;
    logic        validD;
    logic [31:0] instrE;
    logic [31:0] pc8E;
    logic [31:0] rd1E;
    logic [31:0] rd2E;
    logic [31:0] extE;
    logic        validE;
    logic [31:0] stallCnt;
    logic [31:0] bubbleCnt;
  } pipeViewT;

  pipeViewT expQ[$];
  pipeViewT model;
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  fd_de_pipe #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .PCSrcD(PCSrcD),
    .NPCD(NPCD), .InstrF(InstrF), .RD1D(RD1D), .RD2D(RD2D), .ExtD(ExtD),
    .PCF(PCF), .InstrD(InstrD), .PC8D(PC8D), .ValidD(ValidD),
    .InstrE(InstrE), .PC8E(PC8E), .RD1E(RD1E), .RD2E(RD2E), .ExtE(ExtE),
    .ValidE(ValidE), .StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what each stage holds after the coming edge
  task automatic modelStep();
    pipeViewT nxt;
    bit holdPc, holdD, bubble, redirect;
    holdPc   = (StallF === 1'b1);
    holdD    = (StallD === 1'b1);
    bubble   = (FlushE === 1'b1);
    redirect = (PCSrcD === 1'b1);
    nxt = model;
    if (reset === 1'b1) begin
      nxt = '0;
      nxt.pcF    = RESET_PC;
      nxt.instrD = NOP_INSTR;
      nxt.instrE = NOP_INSTR;
    end else begin
      if (!holdPc) nxt.pcF = redirect ? NPCD : model.pcF + 32'd4;
      if (!holdD) begin
        nxt.instrD = InstrF;
        nxt.pc8D   = model.pcF + 32'd8;
        nxt.validD = 1'b1;
      end
      if (bubble) begin
        nxt.instrE = NOP_INSTR;
        nxt.pc8E = 0; nxt.rd1E = 0; nxt.rd2E = 0; nxt.extE = 0;
        nxt.validE = 1'b0;
      end else begin
        nxt.instrE = model.instrD;
        nxt.pc8E   = model.pc8D;
        nxt.rd1E   = RD1D;
        nxt.rd2E   = RD2D;
        nxt.extE   = ExtD;
        nxt.validE = model.validD;
      end
`ifdef PIPE_PERF_CNT_EN
      if (holdD && model.stallCnt != 32'hFFFF_FFFF) nxt.stallCnt = model.stallCnt + 1;
      if (bubble && model.validD && model.bubbleCnt != 32'hFFFF_FFFF)
        nxt.bubbleCnt = model.bubbleCnt + 1;
`endif
    end
    model = nxt;
    expQ.push_back(nxt);
  endtask

  // Drive one cycle of inputs, predict the result, then wait for the next falling edge
  task automatic applyStimulus(input logic rst, input logic sF, input logic sD,
                               input logic fE, input logic br,
                               input logic [31:0] npc, input logic [31:0] instr);
    reset  = rst;
    StallF = sF;
    StallD = sD;
    FlushE = fE;
    PCSrcD = br;
    NPCD   = npc;
    InstrF = instr;
    RD1D   = $urandom;
    RD2D   = $urandom;
    ExtD   = $urandom;
    modelStep();
    @(negedge clk);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL cycle %0d %s got %h want %h", cycle, name, act, exp);
    end
  endtask

  // Compare every visible register against one queued expectation
  task automatic checkOutput(input pipeViewT e);
    cmp("PCF", PCF, e.pcF);
    cmp("InstrD", InstrD, e.instrD);
    cmp("PC8D", PC8D, e.pc8D);
    cmp("ValidD", {31'd0, ValidD}, {31'd0, e.validD});
    cmp("InstrE", InstrE, e.instrE);
    cmp("PC8E", PC8E, e.pc8E);
    cmp("RD1E", RD1E, e.rd1E);
    cmp("RD2E", RD2E, e.rd2E);
    cmp("ExtE", ExtE, e.extE);
    cmp("ValidE", {31'd0, ValidE}, {31'd0, e.validE});
    cmp("StallCnt", StallCnt, e.stallCnt);
    cmp("BubbleCnt", BubbleCnt, e.bubbleCnt);
  endtask

  // Monitor: after each rising edge, pop one expectation and compare
  initial begin
    pipeViewT e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int guard;
    model = '0;
    // Two reset cycles, then free run fetching InstrF = PC
    applyStimulus(1, 0, 0, 0, 0, 0, 32'hdead_beef);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'hdead_beef);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, model.pcF);
    // Load-use stall: F and D frozen, one bubble into E, then resume
    applyStimulus(0, 1, 1, 1, 0, 0, model.pcF);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0, 0, model.pcF);
    // Taken branch: redirect to 3040, delay slot keeps flowing
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_3040, model.pcF);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0, 0, model.pcF);
    // Stall beats redirect, then redirect to 3080 the cycle after
    applyStimulus(0, 1, 0, 0, 1, 32'h0000_3080, model.pcF);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_3080, model.pcF);
    applyStimulus(0, 0, 0, 0, 0, 0, model.pcF);
    // Unknown control inputs straight after reset must behave as deasserted
    applyStimulus(1, 0, 0, 0, 0, 0, model.pcF);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'bx, 1'bx, 1'bx, 1'bx, 32'h0000_5000, model.pcF);
    // Reset arriving in the middle of a stall burst
    applyStimulus(0, 1, 1, 1, 0, 0, model.pcF);
    applyStimulus(1, 1, 1, 1, 0, 0, model.pcF);
    applyStimulus(0, 1, 1, 1, 0, 0, model.pcF);
    applyStimulus(0, 0, 0, 0, 0, 0, model.pcF);
    // Random traffic, including inconsistent control combinations
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                    {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom);
    end
    // Let the monitor drain the queue, bounded
    guard = 0;
    while (expQ.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d pending want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fd_de_pipe.md
Name: fd_de_pipe

Overview:
- Receiving end of the hazard-control interface: holds PC, the IF/ID register and the ID/EX register, and obeys StallF, StallD and FlushE from the hazard unit.
- Sits between instruction memory/fetch, decode (register file, extender, branch compare) and the E-stage ALU of the 5-stage MIPS pipeline.
- Pipeline uses branch delay slots: a taken branch/jump redirects PC only and never squashes IF/ID.

Parameters:
- RESET_PC, 32'h0000_3000, PCF value after reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected into E on a bubble (sll $0,$0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- StallF  in  1  hold PCF.
- StallD  in  1  hold IF/ID.
- FlushE  in  1  load bubble into ID/EX.
- PCSrcD  in  1  branch/jump taken in D.
- NPCD  in  32  redirect target from D.
- InstrF  in  32  instruction read at PCF.
- RD1D  in  32  rs value from D (after forwarding).
- RD2D  in  32  rt value from D (after forwarding).
- ExtD  in  32  extended immediate from D.
- PCF  out  32  fetch PC.
- InstrD  out  32  D-stage instruction.
- PC8D  out  32  D-stage PC+8 (link address).
- ValidD  out  1  D holds a real fetched instruction.
- InstrE  out  32  E-stage instruction.
- PC8E  out  32  E-stage PC+8.
- RD1E  out  32  E-stage rs value.
- RD2E  out  32  E-stage rt value.
- ExtE  out  32  E-stage immediate.
- ValidE  out  1  E holds a real (non-bubble) instruction.
- StallCnt  out  32  stall-cycle counter (see Optional Feature).
- BubbleCnt  out  32  bubble counter (see Optional Feature).

Behaviour:
- Single-cycle latency per stage. All registers update only on rising clk.
- Reset values:
  - PCF = RESET_PC.
  - InstrD = NOP_INSTR; PC8D = 0; ValidD = 0.
  - InstrE = NOP_INSTR; PC8E, RD1E, RD2E, ExtE = 0; ValidE = 0.
  - StallCnt = 0; BubbleCnt = 0.
- Reset has priority over every other input.
- Control inputs are sampled as 4-state safe: X/Z on StallF, StallD, FlushE or PCSrcD is treated as 0 (compare with ===1'b1). This keeps the pipeline advancing during the first cycles while the hazard unit's inputs are still unknown.
- PC register, priority order:
  - StallF → hold.
  - else PCSrcD → NPCD.
  - else PCF + 32'd4; wraps modulo 2^32 with no flag.
  - StallF with PCSrcD both high: PC holds. The branch stays in D and reasserts PCSrcD next cycle.
- IF/ID register:
  - StallD → hold InstrD, PC8D, ValidD.
  - else InstrD = InstrF, PC8D = PCF + 8, ValidD = 1.
  - PCSrcD never clears IF/ID (delay slot).
- ID/EX register:
  - FlushE → InstrE = NOP_INSTR, PC8E/RD1E/RD2E/ExtE = 0, ValidE = 0.
  - else capture InstrD, PC8D, RD1D, RD2D, ExtD and ValidE = ValidD.
  - FlushE wins over normal capture. StallD has no effect on ID/EX.
- Standard stall (StallF = StallD = FlushE = 1):
  - F and D frozen, one bubble enters E.
  - Instruction in D is re-decoded next cycle with fresh forwarded operands.
- Inconsistent combinations (e.g. StallD without StallF) are not errors. Each register follows its own rule. Verification checks per-register behaviour only.
- Reset asserted mid-stall: next cycle all reset values apply. Stall inputs are ignored during reset.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - StallCnt increments on every non-reset cycle with StallD === 1.
  - BubbleCnt increments on every non-reset cycle with FlushE === 1 and ValidD = 1 (a real instruction was displaced).
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: StallCnt and BubbleCnt are constant 0 and no counter flops are built.

Test Plan:
- Reset 2 cycles, then free-run with no stalls, InstrF = PCF → PCF = 3000, 3004, 3008 on successive cycles. InstrD lags PCF by 1 cycle, InstrE by 2. ValidD = 1 from cycle 1, ValidE = 1 from cycle 2.
- lw in E, dependent addu in D; assert StallF = StallD = FlushE = 1 for 1 cycle → PCF and InstrD unchanged that cycle; next InstrE = 0 with ValidE = 0; the cycle after, InstrE = addu. With PIPE_PERF_CNT_EN, StallCnt = 1 and BubbleCnt = 1.
- beq in D at PC 3010, PCSrcD = 1, NPCD = 3040 → next PCF = 3040. Delay-slot instruction from 3014 enters D with ValidD = 1 and is not flushed.
- StallF = 1 and PCSrcD = 1, NPCD = 3080 for 1 cycle, then StallF = 0 with PCSrcD = 1 → PCF holds 1 cycle, then 3080.
- StallF/StallD/FlushE = X after reset → pipeline advances as with 0: PCF 3000 → 3004, ValidE sets normally.
- Reset asserted during a 3-cycle stall burst → next cycle PCF = 3000, InstrD = InstrE = 0, ValidD = ValidE = 0, counters = 0.
